rx_arb_mux: RTL and testbench

Parametrised successor of the RX op-id mux. It collects 8-bit-class op_id lanes from NUM_SW_INST switch instances, qualified by per-instance ack pulses delayed by a configurable number of cycles. Unlike the single-select mux, it captures every acked lane, resolves simultaneous acks with round-robin arbitration, and buffers results in a FIFO with a valid/ready output tagged by source index. It sits between the switch instances and the RX consumer.

---
 rtl/rx_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/rx_arb_mux.sv | 108 ++++++++++
 tb/tb_rx_arb_mux.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared sizing helpers for the RX arbitrated op-id mux.
package rx_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction

    // Lane index width; a single bit is kept even for degenerate sizes.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer, wrapping at N.
module rr_arbiter #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W:0]   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        vld   = 1'b0;
        j     = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                j = {1'b0, ptr} + (IDX_W+1)'(k);
                if (j >= (IDX_W+1)'(N)) j = j - (IDX_W+1)'(N);
                if (!vld && req[j[IDX_W-1:0]]) begin
                    vld = 1'b1;
                    idx = j[IDX_W-1:0];
                end
            end
        end
        if (vld) grant[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (vld)
            ptr <= (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);
    end

endmodule

// File: rtl/rx_arb_mux.sv
// Collects acked op_id lanes from all switch instances, arbitrates round-robin
// and queues {source, op_id} in a FIFO with a valid/ready head.
module rx_arb_mux
    import rx_pkg::*;
#(
    parameter int  NUM_SW_INST = 5,
    parameter int  W_WIDTH     = 8,
    parameter int  ACK_DLY     = 1,
    parameter int  FIFO_DEPTH  = 4,
    localparam int IDX_W       = idx_w(NUM_SW_INST),
    localparam int CNT_W       = cnt_w(FIFO_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [W_WIDTH*NUM_SW_INST-1:0] op_id,
    input  logic [NUM_SW_INST-1:0]         ack,
    input  logic                           out_ready,
    output logic [W_WIDTH-1:0]             op_id_out,
    output logic [IDX_W-1:0]               src_out,
    output logic                           out_valid,
    output logic [CNT_W-1:0]               fifo_cnt,
    output logic                           ovf_err
);

    localparam int AW = clog2(FIFO_DEPTH);

    logic [NUM_SW_INST-1:0] dly [ACK_DLY];
    logic [NUM_SW_INST-1:0] dack, pending, grant, ovf_hit;
    logic [W_WIDTH-1:0]     hold [NUM_SW_INST];
    logic [IDX_W-1:0]       gnt_idx;
    logic                   gnt_vld;
    logic [W_WIDTH-1:0]     fifo_data [FIFO_DEPTH];
    logic [IDX_W-1:0]       fifo_src [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   full, pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ACK_DLY; k++) dly[k] <= '0;
        end else begin
            dly[0] <= ack;
            for (int k = 1; k < ACK_DLY; k++) dly[k] <= dly[k-1];
        end
    end

    assign dack = dly[ACK_DLY-1];

    // A fresh capture on a lane still waiting (and not leaving this cycle) loses the old value.
    assign ovf_hit = dack & pending & ~grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            ovf_err <= 1'b0;
            for (int i = 0; i < NUM_SW_INST; i++) hold[i] <= '0;
        end else begin
            pending <= (pending & ~grant) | dack;
            ovf_err <= |ovf_hit;
            for (int i = 0; i < NUM_SW_INST; i++)
                if (dack[i]) hold[i] <= op_id[lane_lsb(i, W_WIDTH) +: W_WIDTH];
        end
    end

    assign full      = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_ready;

    rr_arbiter #(
        .N     (NUM_SW_INST),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (pending),
        .en    (!full),
        .grant (grant),
        .idx   (gnt_idx),
        .vld   (gnt_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (gnt_vld) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({gnt_vld, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_vld) begin
            fifo_data[wr_ptr] <= hold[gnt_idx];
            fifo_src[wr_ptr]  <= gnt_idx;
        end
    end

    // Head is forced to zero when empty so stale entries never leak out.
    assign op_id_out = out_valid ? fifo_data[rd_ptr] : '0;
    assign src_out   = out_valid ? fifo_src[rd_ptr]  : '0;

endmodule

// File: tb/tb_rx_arb_mux.sv
// Directed bench for rx_arb_mux: default instance plus an ACK_DLY=4 instance.
module tb_rx_arb_mux;

    localparam int N = 5;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [W*N-1:0] op_id, op_id4;
    logic [N-1:0]   ack, ack4;
    logic           out_ready, out_ready4;
    logic [W-1:0]   op_id_out, op_id_out4;
    logic [2:0]     src_out, src_out4;
    logic           out_valid, out_valid4;
    logic [2:0]     fifo_cnt, fifo_cnt4;
    logic           ovf_err, ovf_err4;

    int n_chk  = 0;
    int n_fail = 0;

    rx_arb_mux u_dut (
        .clk       (clk),
        .rst       (rst),
        .op_id     (op_id),
        .ack       (ack),
        .out_ready (out_ready),
        .op_id_out (op_id_out),
        .src_out   (src_out),
        .out_valid (out_valid),
        .fifo_cnt  (fifo_cnt),
        .ovf_err   (ovf_err)
    );

    rx_arb_mux #(.ACK_DLY(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .op_id     (op_id4),
        .ack       (ack4),
        .out_ready (out_ready4),
        .op_id_out (op_id_out4),
        .src_out   (src_out4),
        .out_valid (out_valid4),
        .fifo_cnt  (fifo_cnt4),
        .ovf_err   (ovf_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] v);
        op_id[i*W +: W] = v;
    endtask

    task automatic expect_head(input string tag, input int src, input logic [7:0] data);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_src"}, 32'(src_out), 32'(src));
        check({tag, "_data"}, 32'(op_id_out), 32'(data));
    endtask

    task automatic run_single(input string tag);
        out_ready = 1'b1;
        set_lane(2, 8'h5A);
        ack = 5'b00100;
        tick(1);
        ack = '0;
        check({tag, "_c1_valid"}, 32'(out_valid), 0);
        tick(1);
        check({tag, "_c2_valid"}, 32'(out_valid), 0);
        tick(1);
        expect_head({tag, "_c3"}, 2, 8'h5A);
        check({tag, "_c3_cnt"}, 32'(fifo_cnt), 1);
        tick(1);
        check({tag, "_c4_empty"}, 32'(out_valid), 0);
    endtask

    logic [7:0] exp_d;
    int         s4_src [5] = '{0, 1, 2, 4, 3};
    logic [7:0] s4_dat [5] = '{8'h10, 8'h21, 8'h52, 8'h94, 8'h3C};
    int         s3_cnt [5] = '{4, 3, 3, 2, 1};

    initial begin
        rst = 1'b1; op_id = '0; ack = '0; out_ready = 1'b0;
        op_id4 = '0; ack4 = '0; out_ready4 = 1'b1;
        tick(2);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_cnt", 32'(fifo_cnt), 0);
        check("rst_data", 32'(op_id_out), 0);
        check("rst_src", 32'(src_out), 0);
        check("rst_ovf", 32'(ovf_err), 0);
        check("rst_valid4", 32'(out_valid4), 0);
        rst = 1'b0;
        tick(1);

        // single ack, three-cycle latency
        run_single("s1");

        // simultaneous acks drained in round-robin order from pointer 0
        rst = 1'b1; tick(1); rst = 1'b0; tick(1);
        set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(4, 8'h44);
        out_ready = 1'b1;
        ack = 5'b10011;
        tick(1); ack = '0;
        tick(2);
        expect_head("s2_a", 0, 8'h11);
        tick(1);
        expect_head("s2_b", 1, 8'h22);
        tick(1);
        expect_head("s2_c", 4, 8'h44);
        tick(1);
        check("s2_empty", 32'(out_valid), 0);

        // back-pressure: FIFO saturates, fifth lane waits pending
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) set_lane(i, 8'hA0 + 8'(i));
        for (int i = 0; i < N; i++) begin
            ack = 5'(1) << i;
            tick(1);
        end
        ack = '0;
        tick(1);
        check("s3_full_cnt", 32'(fifo_cnt), 4);
        tick(2);
        check("s3_hold_cnt", 32'(fifo_cnt), 4);
        check("s3_hold_ovf", 32'(ovf_err), 0);
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            exp_d = 8'hA0 + 8'(i);
            expect_head($sformatf("s3_d%0d", i), i, exp_d);
            check($sformatf("s3_cnt%0d", i), 32'(fifo_cnt), 32'(s3_cnt[i]));
            check($sformatf("s3_ovf%0d", i), 32'(ovf_err), 0);
            tick(1);
        end
        check("s3_empty", 32'(out_valid), 0);

        // overwrite of a pending lane while the FIFO is full
        out_ready = 1'b0;
        set_lane(0, 8'h10); set_lane(1, 8'h21); set_lane(2, 8'h52);
        set_lane(3, 8'h33); set_lane(4, 8'h94);
        ack = 5'b10111;
        tick(1); ack = '0;
        tick(5);
        check("s4_full", 32'(fifo_cnt), 4);
        ack = 5'b01000;
        tick(1); ack = '0;
        tick(1);
        set_lane(3, 8'h3C);
        ack = 5'b01000;
        tick(1); ack = '0;
        check("s4_ovf_pre", 32'(ovf_err), 0);
        tick(1);
        check("s4_ovf_pulse", 32'(ovf_err), 1);
        tick(1);
        check("s4_ovf_post", 32'(ovf_err), 0);
        tick(1);
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            expect_head($sformatf("s4_d%0d", i), s4_src[i], s4_dat[i]);
            tick(1);
        end
        check("s4_empty", 32'(out_valid), 0);

        // ACK_DLY=4: data sampled when the delayed ack arrives
        op_id4[15:8] = 8'hAA;
        ack4 = 5'b00010;
        tick(1); ack4 = '0;
        tick(3);
        op_id4[15:8] = 8'hBB;
        tick(1);
        check("s5_c5_valid", 32'(out_valid4), 0);
        tick(1);
        check("s5_c6_valid", 32'(out_valid4), 1);
        check("s5_src", 32'(src_out4), 1);
        check("s5_data", 32'(op_id_out4), 32'h0BB);
        tick(1);
        check("s5_empty", 32'(out_valid4), 0);

        // asynchronous reset with buffered and in-flight data
        out_ready = 1'b0;
        set_lane(0, 8'h01); set_lane(1, 8'h02); set_lane(2, 8'h03); set_lane(4, 8'h05);
        ack = 5'b00111;
        tick(1); ack = '0;
        tick(4);
        ack = 5'b10000;
        tick(1); ack = '0;
        check("s6_cnt3", 32'(fifo_cnt), 3);
        check("s6_valid", 32'(out_valid), 1);
        #3 rst = 1'b1;
        #1;
        check("s6_async_cnt", 32'(fifo_cnt), 0);
        check("s6_async_valid", 32'(out_valid), 0);
        check("s6_async_data", 32'(op_id_out), 0);
        tick(2);
        rst = 1'b0;
        out_ready = 1'b1;
        tick(4);
        check("s6_no_ghost", 32'(out_valid), 0);
        check("s6_no_ghost_cnt", 32'(fifo_cnt), 0);
        run_single("s6_post");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected $finish earlier");
        $fatal(1);
    end

endmodule
